// File: rtl/ysyx_23060184_pkg.sv
// Shared definitions for the write-back unit.
//   RESET_PC_DEFAULT : next-PC value presented after reset
//   wb_sel_e         : write-back data source select
//   F3_*             : load funct3 encodings
//   wbu_state_e      : write-back unit FSM states
package ysyx_23060184_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

   typedef enum logic [1:0] {
      WbAlu = 2'd0,
      WbMem = 2'd1,
      WbPc4 = 2'd2,
      WbCsr = 2'd3
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      StIdle,
      StCommit,
      StWaitPc
   } wbu_state_e;

endpackage

// File: rtl/ysyx_23060184_load_ext.sv
// Load data extraction and extension (combinational).
//   mem_i     : raw aligned load word
//   addr_lo_i : load address bits [1:0], selects byte / halfword lane
//   funct3_i  : load width and signedness
//   data_o    : extended value for the register file
module ysyx_23060184_load_ext
   import ysyx_23060184_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] mem_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      unique case (addr_lo_i)
         2'd0:    byte_sel = mem_i[7:0];
         2'd1:    byte_sel = mem_i[15:8];
         2'd2:    byte_sel = mem_i[23:16];
         default: byte_sel = mem_i[31:24];
      endcase
      // Halfword lane uses only bit 1; bit 0 of a halfword address is ignored.
      half_sel = addr_lo_i[1] ? mem_i[31:16] : mem_i[15:0];
   end

   always_comb begin
      case (funct3_i)
         F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
         // LW and every unused encoding return the full word.
         default: data_o = mem_i;
      endcase
   end

endmodule

// File: rtl/ysyx_23060184_wbu.sv
// Write-back unit: takes one LSU result, writes the register file for exactly
// one cycle, and hands the next PC to the IFU with valid/ready flow control.
//   clk, resetn          : clock, synchronous active-low reset
//   in_valid / in_ready  : upstream handshake (ready only when idle)
//   in_*                 : instruction result fields, captured on accept
//   mtvec, mepc          : trap vector / return PC
//   rf_wvalid/wen/waddr/wdata : register-file write port
//   npc_valid/npc_ready/npc   : next-PC handshake to the IFU
//   retire_cnt           : count of npc handshakes completed
module ysyx_23060184_wbu
   import ysyx_23060184_pkg::*;
#(
   parameter int unsigned    XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_alu,
   input  logic [XLEN-1:0] in_mem,
   input  logic [XLEN-1:0] in_csr,
   input  logic [1:0]      in_addr_lo,
   input  logic [2:0]      in_funct3,
   input  logic [1:0]      in_sel,
   input  logic [4:0]      in_rd,
   input  logic            in_rwen,
   input  logic            in_br_taken,
   input  logic [XLEN-1:0] in_br_target,
   input  logic            in_trap,
   input  logic            in_mret,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   output logic            rf_wvalid,
   output logic            rf_wen,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            npc_valid,
   input  logic            npc_ready,
   output logic [XLEN-1:0] npc,
   output logic [63:0]     retire_cnt
);

   wbu_state_e      state_q, state_d;
   logic            wen_q, wen_d;
   logic [4:0]      waddr_q, waddr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] npc_q, npc_d;
   logic [63:0]     retire_q, retire_d;

   logic            accept;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] wb_data;
   logic [XLEN-1:0] next_pc;

   ysyx_23060184_load_ext #(
      .XLEN (XLEN)
   ) u_load_ext (
      .mem_i     (in_mem),
      .addr_lo_i (in_addr_lo),
      .funct3_i  (in_funct3),
      .data_o    (load_data)
   );

   assign in_ready  = (state_q == StIdle);
   assign rf_wvalid = (state_q == StCommit);
   assign npc_valid = (state_q != StIdle);
   assign accept    = in_valid && in_ready;
   assign pc_plus4  = in_pc + XLEN'(4);

   always_comb begin
      unique case (wb_sel_e'(in_sel))
         WbAlu:   wb_data = in_alu;
         WbMem:   wb_data = load_data;
         WbPc4:   wb_data = pc_plus4;
         default: wb_data = in_csr;
      endcase
   end

   // Trap beats mret beats branch.
   always_comb begin
      if (in_trap)          next_pc = mtvec;
      else if (in_mret)     next_pc = mepc;
      else if (in_br_taken) next_pc = in_br_target;
      else                  next_pc = pc_plus4;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (accept) state_d = StCommit;
         StCommit: state_d = npc_ready ? StIdle : StWaitPc;
         StWaitPc: if (npc_ready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Write-port and npc values are computed at accept and held until the next
   // accept, so they stay stable through any IFU backpressure.
   always_comb begin
      wen_d    = wen_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      npc_d    = npc_q;
      retire_d = retire_q + {63'd0, npc_valid && npc_ready};
      if (accept) begin
         wen_d   = in_rwen && (in_rd != 5'd0) && !in_trap;
         waddr_d = in_rd;
         wdata_d = wb_data;
         npc_d   = next_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= StIdle;
         wen_q    <= 1'b0;
         waddr_q  <= 5'd0;
         wdata_q  <= '0;
         npc_q    <= RESET_PC;
         retire_q <= 64'd0;
      end else begin
         state_q  <= state_d;
         wen_q    <= wen_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         npc_q    <= npc_d;
         retire_q <= retire_d;
      end
   end

   assign rf_wen     = wen_q;
   assign rf_waddr   = waddr_q;
   assign rf_wdata   = wdata_q;
   assign npc        = npc_q;
   assign retire_cnt = retire_q;

endmodule

// File: tb/tb_ysyx_23060184_wbu.sv
// Self-checking bench for the write-back unit: directed vector table,
// hand-written backpressure / throughput / reset sequences, and random
// transactions checked against a behavioural model.
module tb_ysyx_23060184_wbu;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid, in_ready;
   logic [31:0] in_pc, in_alu, in_mem, in_csr;
   logic [1:0]  in_addr_lo;
   logic [2:0]  in_funct3;
   logic [1:0]  in_sel;
   logic [4:0]  in_rd;
   logic        in_rwen, in_br_taken, in_trap, in_mret;
   logic [31:0] in_br_target, mtvec, mepc;
   logic        rf_wvalid, rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        npc_valid, npc_ready;
   logic [31:0] npc;
   logic [63:0] retire_cnt;

   always #5 clk = ~clk;

   ysyx_23060184_wbu dut (
      .clk          (clk),
      .resetn       (resetn),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_pc        (in_pc),
      .in_alu       (in_alu),
      .in_mem       (in_mem),
      .in_csr       (in_csr),
      .in_addr_lo   (in_addr_lo),
      .in_funct3    (in_funct3),
      .in_sel       (in_sel),
      .in_rd        (in_rd),
      .in_rwen      (in_rwen),
      .in_br_taken  (in_br_taken),
      .in_br_target (in_br_target),
      .in_trap      (in_trap),
      .in_mret      (in_mret),
      .mtvec        (mtvec),
      .mepc         (mepc),
      .rf_wvalid    (rf_wvalid),
      .rf_wen       (rf_wen),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .npc_valid    (npc_valid),
      .npc_ready    (npc_ready),
      .npc          (npc),
      .retire_cnt   (retire_cnt)
   );

   typedef struct {
      logic [31:0] pc, alu, mem, csr;
      logic [1:0]  lo;
      logic [2:0]  f3;
      logic [1:0]  sel;
      logic [4:0]  rd;
      logic        rwen, br, trap, mret;
      logic [31:0] tgt, tvec, epc;
      logic        exp_wen;
      logic [31:0] exp_wdata, exp_npc;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] exp_retire;
   vec_t        tbl[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] pc, alu, mem, csr, input logic [1:0] lo,
                               input logic [2:0] f3, input logic [1:0] sel, input logic [4:0] rd,
                               input logic rwen, br, trap, mret,
                               input logic [31:0] tgt, tvec, epc,
                               input logic ew, input logic [31:0] ed, en);
      vec_t v;
      v.pc = pc; v.alu = alu; v.mem = mem; v.csr = csr; v.lo = lo; v.f3 = f3; v.sel = sel;
      v.rd = rd; v.rwen = rwen; v.br = br; v.trap = trap; v.mret = mret; v.tgt = tgt;
      v.tvec = tvec; v.epc = epc; v.exp_wen = ew; v.exp_wdata = ed; v.exp_npc = en;
      return v;
   endfunction

   // Behavioural reference: plain arithmetic on the instruction fields.
   function automatic vec_t model(input vec_t v);
      vec_t        r;
      logic [31:0] b, h;
      r = v;
      b = (v.mem >> (8 * v.lo)) % 256;
      h = (v.mem >> (16 * (v.lo / 2))) % 65536;
      case (v.sel)
         2'd0: r.exp_wdata = v.alu;
         2'd2: r.exp_wdata = v.pc + 32'd4;
         2'd3: r.exp_wdata = v.csr;
         default: begin
            if (v.f3 == 3'd0)      r.exp_wdata = (b >= 128) ? b - 256 : b;
            else if (v.f3 == 3'd4) r.exp_wdata = b;
            else if (v.f3 == 3'd1) r.exp_wdata = (h >= 32768) ? h - 65536 : h;
            else if (v.f3 == 3'd5) r.exp_wdata = h;
            else                   r.exp_wdata = v.mem;
         end
      endcase
      r.exp_wen = v.rwen && (v.rd != 0) && !v.trap;
      if (v.trap)      r.exp_npc = v.tvec;
      else if (v.mret) r.exp_npc = v.epc;
      else if (v.br)   r.exp_npc = v.tgt;
      else             r.exp_npc = v.pc + 32'd4;
      return r;
   endfunction

   task automatic drive(input vec_t v);
      in_pc = v.pc; in_alu = v.alu; in_mem = v.mem; in_csr = v.csr; in_addr_lo = v.lo;
      in_funct3 = v.f3; in_sel = v.sel; in_rd = v.rd; in_rwen = v.rwen; in_br_taken = v.br;
      in_trap = v.trap; in_mret = v.mret; in_br_target = v.tgt; mtvec = v.tvec; mepc = v.epc;
   endtask

   task automatic check_commit(input string tag, input vec_t v);
      check({tag, ".rf_wvalid"}, rf_wvalid, 1);
      check({tag, ".npc_valid"}, npc_valid, 1);
      check({tag, ".in_ready"}, in_ready, 0);
      check({tag, ".rf_wen"}, rf_wen, v.exp_wen);
      check({tag, ".rf_waddr"}, rf_waddr, v.rd);
      if (v.exp_wen) check({tag, ".rf_wdata"}, rf_wdata, v.exp_wdata);
      check({tag, ".npc"}, npc, v.exp_npc);
   endtask

   // One transaction with the IFU stalling for 'stall' cycles after COMMIT.
   task automatic apply(input string tag, input vec_t v, input int stall);
      @(negedge clk);
      drive(v);
      in_valid  = 1'b1;
      npc_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      check_commit(tag, v);
      npc_ready = (stall == 0);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({tag, ".wait.rf_wvalid"}, rf_wvalid, 0);
         check({tag, ".wait.npc_valid"}, npc_valid, 1);
         check({tag, ".wait.npc"}, npc, v.exp_npc);
         check({tag, ".wait.in_ready"}, in_ready, 0);
         if (i == stall - 1) npc_ready = 1'b1;
      end
      @(negedge clk);
      npc_ready = 1'b0;
      exp_retire++;
      check({tag, ".idle.in_ready"}, in_ready, 1);
      check({tag, ".idle.npc_valid"}, npc_valid, 0);
      check({tag, ".idle.rf_wvalid"}, rf_wvalid, 0);
      check({tag, ".retire_cnt"}, retire_cnt, exp_retire);
      check({tag, ".held.rf_waddr"}, rf_waddr, v.rd);
      if (v.exp_wen) check({tag, ".held.rf_wdata"}, rf_wdata, v.exp_wdata);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v, a, b;
      string nm;

      tbl.push_back(mk(32'h80000000, 32'h12345678, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0,
                       1, 32'h12345678, 32'h80000004));
      tbl.push_back(mk(32'h80000004, 0, 32'h80FF7F01, 0, 3, 3'b000, 1, 6, 1, 0, 0, 0, 0, 0, 0,
                       1, 32'hFFFFFF80, 32'h80000008));
      tbl.push_back(mk(32'h80000008, 0, 32'h80FF7F01, 0, 3, 3'b100, 1, 6, 1, 0, 0, 0, 0, 0, 0,
                       1, 32'h00000080, 32'h8000000C));
      tbl.push_back(mk(32'h8000000C, 0, 32'h80FF7F01, 0, 2, 3'b101, 1, 6, 1, 0, 0, 0, 0, 0, 0,
                       1, 32'h000080FF, 32'h80000010));
      tbl.push_back(mk(32'h80000010, 0, 32'h80FF7F01, 0, 2, 3'b001, 1, 6, 1, 0, 0, 0, 0, 0, 0,
                       1, 32'hFFFF80FF, 32'h80000014));
      tbl.push_back(mk(32'h80000014, 0, 32'h80FF7F01, 0, 0, 3'b010, 1, 6, 1, 0, 0, 0, 0, 0, 0,
                       1, 32'h80FF7F01, 32'h80000018));
      tbl.push_back(mk(32'h80000018, 0, 32'h80FF7F01, 0, 1, 3'b011, 1, 6, 1, 0, 0, 0, 0, 0, 0,
                       1, 32'h80FF7F01, 32'h8000001C));
      tbl.push_back(mk(32'h8000001C, 0, 32'h80FF7F01, 0, 1, 3'b100, 1, 7, 1, 0, 0, 0, 0, 0, 0,
                       1, 32'h0000007F, 32'h80000020));
      tbl.push_back(mk(32'h80000020, 32'hDEADBEEF, 0, 0, 0, 0, 0, 10, 1, 1, 1, 1, 32'h80000300,
                       32'h80001000, 32'h80002000, 0, 0, 32'h80001000));
      tbl.push_back(mk(32'h80000024, 1, 0, 0, 0, 0, 0, 11, 1, 1, 0, 1, 32'h80000300,
                       32'h80001000, 32'h80002000, 1, 1, 32'h80002000));
      tbl.push_back(mk(32'h80000028, 2, 0, 0, 0, 0, 0, 12, 1, 1, 0, 0, 32'h80000300,
                       32'h80001000, 32'h80002000, 1, 2, 32'h80000300));
      tbl.push_back(mk(32'h8000002C, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,
                       0, 0, 32'h80000030));
      tbl.push_back(mk(32'hFFFFFFFC, 4, 0, 0, 0, 0, 2, 1, 1, 1, 0, 0, 32'h80000040, 0, 0,
                       1, 32'h00000000, 32'h80000040));
      tbl.push_back(mk(32'h80000040, 0, 0, 32'h00001800, 0, 0, 3, 7, 1, 0, 0, 0, 0, 0, 0,
                       1, 32'h00001800, 32'h80000044));
      tbl.push_back(mk(32'h80000044, 5, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0,
                       0, 5, 32'h80000048));

      // Reset with inputs active: they must be ignored.
      resetn    = 1'b0;
      npc_ready = 1'b1;
      drive(tbl[0]);
      in_valid = 1'b1;
      repeat (2) @(negedge clk);
      check("rst.in_ready", in_ready, 1);
      check("rst.rf_wvalid", rf_wvalid, 0);
      check("rst.rf_wen", rf_wen, 0);
      check("rst.rf_waddr", rf_waddr, 0);
      check("rst.rf_wdata", rf_wdata, 0);
      check("rst.npc_valid", npc_valid, 0);
      check("rst.npc", npc, 32'h80000000);
      check("rst.retire_cnt", retire_cnt, 0);
      in_valid   = 1'b0;
      npc_ready  = 1'b0;
      resetn     = 1'b1;
      exp_retire = 0;

      foreach (tbl[i]) begin
         nm = $sformatf("vec%0d", i);
         apply(nm, tbl[i], 0);
      end

      // IFU backpressure for 3 cycles.
      apply("stall3", tbl[0], 3);

      // Back-to-back: one instruction every two cycles.
      a = tbl[0];
      b = tbl[13];
      @(negedge clk);
      drive(a);
      in_valid  = 1'b1;
      npc_ready = 1'b1;
      @(negedge clk);
      check_commit("b2b.a", a);
      drive(b);
      @(negedge clk);
      check("b2b.gap.in_ready", in_ready, 1);
      check("b2b.gap.rf_wvalid", rf_wvalid, 0);
      @(negedge clk);
      in_valid = 1'b0;
      check_commit("b2b.b", b);
      @(negedge clk);
      npc_ready  = 1'b0;
      exp_retire = exp_retire + 2;
      check("b2b.retire_cnt", retire_cnt, exp_retire);

      // Random transactions against the model.
      for (int i = 0; i < 40; i++) begin
         v.pc   = $urandom; v.alu = $urandom; v.mem = $urandom; v.csr = $urandom;
         v.lo   = 2'($urandom); v.f3 = 3'($urandom); v.sel = 2'($urandom);
         v.rd   = 5'($urandom); v.rwen = 1'($urandom); v.br = 1'($urandom);
         v.trap = ($urandom_range(0, 5) == 0); v.mret = ($urandom_range(0, 5) == 0);
         v.tgt  = $urandom; v.tvec = $urandom; v.epc = $urandom;
         v = model(v);
         nm = $sformatf("rnd%0d", i);
         apply(nm, v, $urandom_range(0, 2));
      end

      // Reset while waiting for the IFU drops the pending redirect.
      @(negedge clk);
      drive(tbl[1]);
      in_valid  = 1'b1;
      npc_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("wrst.pre.npc_valid", npc_valid, 1);
      check("wrst.pre.rf_wvalid", rf_wvalid, 0);
      resetn   = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      check("wrst.npc_valid", npc_valid, 0);
      check("wrst.npc", npc, 32'h80000000);
      check("wrst.retire_cnt", retire_cnt, 0);
      check("wrst.rf_wen", rf_wen, 0);
      check("wrst.rf_wdata", rf_wdata, 0);
      @(negedge clk);
      check("wrst.hold.npc_valid", npc_valid, 0);
      in_valid   = 1'b0;
      resetn     = 1'b1;
      exp_retire = 0;
      @(negedge clk);
      check("wrst.rel.in_ready", in_ready, 1);
      apply("post_rst", tbl[13], 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
